nes_pad_responder: RTL
======================

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for latch and pulse, legal range 2..3.
REQ-002 Parameter FILTER_LEN, default 4: consecutive equal samples required before a filtered input is accepted; used only with NES_GLITCH_FILTER_EN.
REQ-003 clock  in  1  system clock (50 MHz).
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 buttons  in  8  button state, active-high; bit7=A, 6=B, 5=Select, 4=Start, 3=Up, 2=Down, 1=Left, 0=Right.
REQ-006 latch  in  1  host latch, asynchronous to clock.
REQ-007 pulse  in  1  host shift clock, asynchronous to clock.
REQ-008 data  out  1  serial button data, active-low (0=pressed), registered.
REQ-009 frame_strobe  out  1  one-cycle pulse on accepted latch falling edge.
REQ-010 frame_buttons  out  8  button snapshot taken at latch fall, active-high.
REQ-011 bit_index  out  4  shifts completed since last load, 0..8, saturating.

Function
REQ-012 latch and pulse SHALL each pass through SYNC_STAGES flops before any use; rise/fall detection SHALL use the synchronized value and its one-cycle-delayed copy.
REQ-013 Shift register sr[7:0] SHALL hold ~buttons; data SHALL equal sr[7].
REQ-014 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-015 IDLE->LOAD on synchronized latch high; any state->LOAD on synchronized latch high, aborting a shift in progress.
REQ-016 In LOAD, sr SHALL reload ~buttons every clock (transparent parallel load); pulse edges SHALL be ignored; bit_index SHALL be 0.
REQ-017 LOAD->SHIFT on latch falling edge; same cycle: frame_strobe=1 and frame_buttons<=buttons.
REQ-018 In SHIFT, each pulse rising edge SHALL shift sr left one bit, fill bit0 with 1, and increment bit_index.
REQ-019 SHIFT->DONE when bit_index reaches 8; in DONE data SHALL be 1 and further pulse rises SHALL leave sr, data, bit_index unchanged.
REQ-020 Latch high and pulse rising edge in the same cycle: load SHALL win and no shift SHALL occur.
REQ-021 buttons changes during SHIFT/DONE SHALL NOT affect sr or data.
REQ-022 Without the filter, data SHALL reflect a pulse rise or latch change no later than SYNC_STAGES+2 clocks after the input transition.

Reset
REQ-023 On reset assertion, immediately: state=IDLE, sr=8'hFF, data=1, bit_index=0, frame_strobe=0, frame_buttons=8'h00, all synchronizer and filter flops=0.
REQ-024 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in IDLE for the next latch high.

Configuration
REQ-025 Macro NES_GLITCH_FILTER_EN defined: each synchronized input SHALL change its accepted value only after FILTER_LEN consecutive equal samples; added latency FILTER_LEN-1 clocks.
REQ-026 Macro NES_GLITCH_FILTER_EN undefined: accepted value equals synchronizer output; no filter logic.

Structure
REQ-027 Package nes_pkg SHALL hold button bit-index constants (NES_BTN_A..NES_BTN_RIGHT), the FSM state typedef, and the default FILTER_LEN.
REQ-028 Sub-module nes_input_sync (synchronizer plus optional filter) SHALL be instantiated once for latch and once for pulse.

Verification
REQ-029 buttons=8'b1000_0001, latch high 600 clk, low, 8 pulse rises 600 clk apart -> data before each rise: 0,1,1,1,1,1,1,0; afterwards 1; bit_index=8; frame_buttons=8'h81.
REQ-030 buttons=8'hFF, change to 8'h00 after latch fall -> data sequence all 0 (pressed); frame_buttons=8'hFF.
REQ-031 latch re-asserted after 3 shifts, buttons=8'h40 -> bit_index=0, data=1, then 0 after first shift (B pressed).
REQ-032 latch rises same clock as pulse rises -> no shift; sr=~buttons; bit_index=0.
REQ-033 reset after 5 shifts -> data=1, bit_index=0, state IDLE; next frame with buttons=8'h10 shifts 1,1,1,0,1,1,1,1.
REQ-034 with NES_GLITCH_FILTER_EN, 2-clock pulse glitch during SHIFT -> no shift; bit_index unchanged.

Source files
------------

// File: rtl/nes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nes_pkg: shared constants, FSM state type and helpers for the NES    |
// | pad responder. Rev 1.0                                               |
// +----------------------------------------------------------------------+
package nes_pkg;

    localparam int unsigned NES_NUM_BUTTONS        = 8;
    localparam int unsigned NES_FILTER_LEN_DEFAULT = 4;

    // Bit positions in the button vector; A is shifted out first.
    localparam int unsigned NES_BTN_A      = 7;
    localparam int unsigned NES_BTN_B      = 6;
    localparam int unsigned NES_BTN_SELECT = 5;
    localparam int unsigned NES_BTN_START  = 4;
    localparam int unsigned NES_BTN_UP     = 3;
    localparam int unsigned NES_BTN_DOWN   = 2;
    localparam int unsigned NES_BTN_LEFT   = 1;
    localparam int unsigned NES_BTN_RIGHT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } nes_state_e;

    function automatic logic [NES_NUM_BUTTONS-1:0] nes_shift_in_one(
        input logic [NES_NUM_BUTTONS-1:0] sr
    );
        return {sr[NES_NUM_BUTTONS-2:0], 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/nes_input_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nes_input_sync: multi-flop synchronizer with optional glitch filter  |
// | (enabled by NES_GLITCH_FILTER_EN). Rev 1.0                           |
// +----------------------------------------------------------------------+
module nes_input_sync
    import nes_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = NES_FILTER_LEN_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || FILTER_LEN < 2) begin : g_param_check
        $error("nes_input_sync: SYNC_STAGES must be 2..3 and FILTER_LEN >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

`ifdef NES_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             accept;

    // The FILTER_LEN-th differing sample is passed through combinationally,
    // so the added latency is FILTER_LEN-1 clocks.
    assign accept = (sample != level_q) && (cnt_q == CNT_W'(FILTER_LEN - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sample == level_q) begin
            cnt_q   <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            level_q <= sample;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign level_o = accept ? sample : level_q;
`else
    assign level_o = sample;
`endif

endmodule

`default_nettype wire

// File: rtl/nes_pad_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nes_pad_responder: NES controller emulation (latch/pulse/data).      |
// | Optional input glitch filter: NES_GLITCH_FILTER_EN. Rev 1.0          |
// +----------------------------------------------------------------------+
module nes_pad_responder
    import nes_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = NES_FILTER_LEN_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NES_NUM_BUTTONS-1:0] buttons_i,
    input  logic                       latch_i,
    input  logic                       pulse_i,
    output logic                       data_o,
    output logic                       frame_strobe_o,
    output logic [NES_NUM_BUTTONS-1:0] frame_buttons_o,
    output logic [3:0]                 bit_index_o
);

    logic latch_s, pulse_s;
    logic latch_prev_q, pulse_prev_q;
    logic latch_fall, pulse_rise;

    nes_input_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_latch_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (latch_i),
        .level_o (latch_s)
    );

    nes_input_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_pulse_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (pulse_i),
        .level_o (pulse_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latch_prev_q <= 1'b0;
            pulse_prev_q <= 1'b0;
        end else begin
            latch_prev_q <= latch_s;
            pulse_prev_q <= pulse_s;
        end
    end

    assign latch_fall = latch_prev_q & ~latch_s;
    assign pulse_rise = pulse_s & ~pulse_prev_q;

    nes_state_e                 state_q, state_d;
    logic [NES_NUM_BUTTONS-1:0] sr_q, sr_d;
    logic [NES_NUM_BUTTONS-1:0] fbtn_q, fbtn_d;
    logic [3:0]                 idx_q, idx_d;
    logic                       strobe_q, strobe_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sr_q     <= '1;
            fbtn_q   <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            fbtn_q   <= fbtn_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        fbtn_d   = fbtn_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        // Latch high overrides everything, including a same-cycle pulse edge.
        if (latch_s) begin
            state_d = ST_LOAD;
            sr_d    = ~buttons_i;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (latch_fall) begin
                        state_d  = ST_SHIFT;
                        sr_d     = ~buttons_i;
                        fbtn_d   = buttons_i;
                        strobe_d = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (pulse_rise) begin
                        sr_d  = nes_shift_in_one(sr_q);
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // After eight shifts the register is all ones, so DONE drives data high.
    assign data_o          = sr_q[NES_BTN_A];
    assign frame_strobe_o  = strobe_q;
    assign frame_buttons_o = fbtn_q;
    assign bit_index_o     = idx_q;

endmodule

`default_nettype wire
